// File: rtl/frame_recover_pkg.sv
// frame_recover_pkg
//   Shared types and constants for the pixel-stream framer.
//   fr_state_t   : framer state (SYNC, ACTIVE, FULL)
//   FRAME_CNT_W  : width of the closed-frame counter
package frame_recover_pkg;

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    ACTIVE = 2'd1,
    FULL   = 2'd2
  } fr_state_t;

  localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/frame_recover_if.sv
// frame_recover_if
//   Groups the camera-side inputs and the framed pixel-stream outputs
//   of frame_recover.
//   master : camera / consumer side (drives the strobe, pixel and
//            frame_done; observes the framed stream)
//   slave  : the framer itself
//   Parameters PIXEL_W, HW, VW must match the framer's PIXEL_W,
//   $clog2(WIDTH) and $clog2(HEIGHT).
interface frame_recover_if #(
  parameter int PIXEL_W = 16,
  parameter int HW      = 9,
  parameter int VW      = 9
) ();

  logic                                   valid_pixel_in;
  logic [PIXEL_W-1:0]                     pixel_in;
  logic                                   frame_done_in;
  logic [PIXEL_W-1:0]                     pixel_out;
  logic                                   data_valid_out;
  logic [HW-1:0]                          hcount_out;
  logic [VW-1:0]                          vcount_out;
  logic                                   sof_out;
  logic                                   eol_out;
  logic                                   eof_out;
  logic                                   short_err_out;
  logic                                   ovf_err_out;
  logic [frame_recover_pkg::FRAME_CNT_W-1:0] frame_count_out;

  modport master (
    output valid_pixel_in, pixel_in, frame_done_in,
    input  pixel_out, data_valid_out, hcount_out, vcount_out,
           sof_out, eol_out, eof_out, short_err_out, ovf_err_out,
           frame_count_out
  );

  modport slave (
    input  valid_pixel_in, pixel_in, frame_done_in,
    output pixel_out, data_valid_out, hcount_out, vcount_out,
           sof_out, eol_out, eof_out, short_err_out, ovf_err_out,
           frame_count_out
  );

endinterface

// File: rtl/frame_recover_strobe_qualify.sv
// strobe_qualify
//   Turns the synchronised pixel strobe into a one-cycle accept pulse.
//   EDGE_MODE=1 : accept on the rising edge of valid_in
//   EDGE_MODE=0 : accept every cycle valid_in is high
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     valid_in   : pixel strobe
//     acc_out    : accept strobe (combinational from valid_in and prev)
module strobe_qualify #(
  parameter int EDGE_MODE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid_in,
  output logic acc_out
);

  logic prev_q;
  logic prev_d;

  // prev tracks the strobe every cycle, regardless of what the framer
  // does with the accept, so edges are never double-counted.
  always_comb begin
    prev_d = valid_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= prev_d;
  end

  assign acc_out = (EDGE_MODE != 0) ? (valid_in & ~prev_q) : valid_in;

endmodule

// File: rtl/frame_recover.sv
// frame_recover
//   Pixel-stream framer: converts a qualified pixel strobe plus an
//   end-of-frame pulse into a registered stream with bounded h/v
//   counts, SOF/EOL/EOF markers and per-frame size-error pulses.
//   Ports:
//     system_clk_in : system clock
//     rst_n_in      : asynchronous reset, active-low
//     bus           : frame_recover_if.slave (strobe/pixel/frame_done in,
//                     pixel/valid/h/v/markers/errors/frame count out)
//   All outputs are registered; one cycle from accept to output.
module frame_recover
  import frame_recover_pkg::*;
#(
  parameter int WIDTH     = 480,
  parameter int HEIGHT    = 320,
  parameter int PIXEL_W   = 16,
  parameter int EDGE_MODE = 1
) (
  input  logic     system_clk_in,
  input  logic     rst_n_in,
  frame_recover_if.slave bus
);

  localparam int HW = $clog2(WIDTH);
  localparam int VW = $clog2(HEIGHT);
  localparam logic [HW-1:0] H_LAST = HW'(WIDTH - 1);
  localparam logic [VW-1:0] V_LAST = VW'(HEIGHT - 1);

  logic acc;

  strobe_qualify #(
    .EDGE_MODE (EDGE_MODE)
  ) u_strobe_qualify (
    .clk      (system_clk_in),
    .rst_n    (rst_n_in),
    .valid_in (bus.valid_pixel_in),
    .acc_out  (acc)
  );

  fr_state_t              state_q,     state_d;
  logic [HW-1:0]          h_q,         h_d;
  logic [VW-1:0]          v_q,         v_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [PIXEL_W-1:0]     pixel_q,     pixel_d;
  logic                   dv_q,        dv_d;
  logic [HW-1:0]          hcount_q,    hcount_d;
  logic [VW-1:0]          vcount_q,    vcount_d;
  logic                   sof_q,       sof_d;
  logic                   eol_q,       eol_d;
  logic                   eof_q,       eof_d;
  logic                   short_q,     short_d;
  logic                   ovf_q,       ovf_d;

  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    v_d         = v_q;
    frame_cnt_d = frame_cnt_q;
    pixel_d     = pixel_q;
    hcount_d    = hcount_q;
    vcount_d    = vcount_q;
    dv_d        = 1'b0;
    sof_d       = 1'b0;
    eol_d       = 1'b0;
    eof_d       = 1'b0;
    short_d     = 1'b0;
    ovf_d       = 1'b0;

    case (state_q)
      // Wait for a frame boundary so the first emitted frame is complete.
      SYNC: begin
        if (bus.frame_done_in) begin
          state_d = ACTIVE;
          h_d     = '0;
          v_d     = '0;
        end
      end

      // frame_done wins over a coincident accept; that pixel is dropped.
      // Any close from ACTIVE is short, since a full frame leaves ACTIVE.
      ACTIVE: begin
        if (bus.frame_done_in) begin
          eof_d       = 1'b1;
          short_d     = 1'b1;
          frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
          h_d         = '0;
          v_d         = '0;
        end else if (acc) begin
          dv_d     = 1'b1;
          pixel_d  = bus.pixel_in;
          hcount_d = h_q;
          vcount_d = v_q;
          sof_d    = (h_q == '0) && (v_q == '0);
          eol_d    = (h_q == H_LAST);
          if (h_q == H_LAST) begin
            h_d = '0;
            if (v_q == V_LAST) begin
              v_d     = '0;
              state_d = FULL;
            end else begin
              v_d = v_q + VW'(1);
            end
          end else begin
            h_d = h_q + HW'(1);
          end
        end
      end

      FULL: begin
        if (bus.frame_done_in) begin
          eof_d       = 1'b1;
          frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
          state_d     = ACTIVE;
          h_d         = '0;
          v_d         = '0;
        end else if (acc) begin
          ovf_d = 1'b1;
        end
      end

      default: begin
        state_d = SYNC;
      end
    endcase
  end

  always_ff @(posedge system_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= SYNC;
      h_q         <= '0;
      v_q         <= '0;
      frame_cnt_q <= '0;
      pixel_q     <= '0;
      dv_q        <= 1'b0;
      hcount_q    <= '0;
      vcount_q    <= '0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      eof_q       <= 1'b0;
      short_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      v_q         <= v_d;
      frame_cnt_q <= frame_cnt_d;
      pixel_q     <= pixel_d;
      dv_q        <= dv_d;
      hcount_q    <= hcount_d;
      vcount_q    <= vcount_d;
      sof_q       <= sof_d;
      eol_q       <= eol_d;
      eof_q       <= eof_d;
      short_q     <= short_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.pixel_out       = pixel_q;
  assign bus.data_valid_out  = dv_q;
  assign bus.hcount_out      = hcount_q;
  assign bus.vcount_out      = vcount_q;
  assign bus.sof_out         = sof_q;
  assign bus.eol_out         = eol_q;
  assign bus.eof_out         = eof_q;
  assign bus.short_err_out   = short_q;
  assign bus.ovf_err_out     = ovf_q;
  assign bus.frame_count_out = frame_cnt_q;

endmodule
